dma_pattern_writer: RTL and testbench

- Write-side counterpart of the DMA read-back checker. It accepts a serialized byte stream and packs it into little-endian 32-bit words.
- Each word is issued as a DMA write request to the AHB-Lite master, starting at the RCC-programmed DMA address, with the address incrementing by 4 per word.
- It enforces the RCC buffer length, flushes a trailing partial word with byte strobes, and reports completion and length errors.

---
 rtl/dma_pattern_writer.sv | 156 +++++++++++++++
 tb/tb_dma_pattern_writer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_pattern_writer.sv
// Packs a byte stream into little-endian 32-bit words and issues them
// as incrementing-address DMA writes, with length checking and flush.
module dma_pattern_writer #(
   parameter int WORD_Q_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] i_RCC_DMA_ADDR_HIGH,
   input  logic [15:0] i_RCC_DMA_ADDR_LOW,
   input  logic [5:0]  i_RCC_BUFFER_LENGTH,
   input  logic        Write_Request,
   input  logic [7:0]  i_byte,
   input  logic        i_byte_valid,
   input  logic        i_byte_last,
   output logic        o_byte_ready,
   output logic        DMA_WRITE,
   output logic [31:0] DMA_WRITE_addr,
   output logic [31:0] DMA_WRITE_data,
   output logic [3:0]  DMA_WRITE_strb,
   input  logic        i_DMA_WRITE_ready,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_len_error
);
   localparam int AW = $clog2(WORD_Q_DEPTH);
   localparam logic [AW:0] Q_FULL = (AW+1)'(WORD_Q_DEPTH);
   localparam logic [AW:0] Q_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] P_ONE = AW'(1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   state_t      state;
   logic [31:0] addr;
   logic [5:0]  len;
   logic [5:0]  byte_cnt;
   logic [1:0]  pack_cnt;
   logic [31:0] pack_data;
   logic [3:0]  pack_strb;
   logic        len_err;

   logic [31:0]   q_data [WORD_Q_DEPTH];
   logic [3:0]    q_strb [WORD_Q_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   q_cnt;

   logic        q_empty;
   logic        q_full;
   logic        pop;
   logic        accept;
   logic [6:0]  cnt_nxt;
   logic        at_len;
   logic        term;
   logic        push;
   logic [31:0] word_data;
   logic [3:0]  word_strb;

   assign q_empty = (q_cnt == '0);
   assign q_full  = (q_cnt == Q_FULL);

   assign DMA_WRITE = ((state == COLLECT) || (state == DRAIN))
                      && !q_empty;
   assign pop = DMA_WRITE && i_DMA_WRITE_ready;

   assign o_byte_ready = (state == COLLECT) && (!q_full || pop);
   assign accept = i_byte_valid && o_byte_ready;

   assign cnt_nxt = {1'b0, byte_cnt} + 7'd1;
   assign at_len  = (cnt_nxt == {1'b0, len});
   assign term    = accept && (i_byte_last || at_len);
   assign push    = accept && ((pack_cnt == 2'd3) || i_byte_last || at_len);

   assign word_data = pack_data | ({24'd0, i_byte} << {pack_cnt, 3'b000});
   assign word_strb = pack_strb | (4'b0001 << pack_cnt);

   assign DMA_WRITE_addr = addr;
   assign DMA_WRITE_data = DMA_WRITE ? q_data[rd_ptr] : 32'd0;
   assign DMA_WRITE_strb = DMA_WRITE ? q_strb[rd_ptr] : 4'd0;

   assign o_busy      = (state != IDLE);
   assign o_done      = (state == DONE);
   assign o_len_error = len_err;

   always_ff @(posedge CLK) begin
      if (push) begin
         q_data[wr_ptr] <= word_data;
         q_strb[wr_ptr] <= word_strb;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         addr      <= 32'd0;
         len       <= 6'd0;
         byte_cnt  <= 6'd0;
         pack_cnt  <= 2'd0;
         pack_data <= 32'd0;
         pack_strb <= 4'd0;
         len_err   <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         q_cnt     <= '0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + P_ONE;
            addr   <= addr + 32'd4;
         end
         if (push) begin
            wr_ptr <= wr_ptr + P_ONE;
         end
         if (push && !pop) begin
            q_cnt <= q_cnt + Q_ONE;
         end else if (pop && !push) begin
            q_cnt <= q_cnt - Q_ONE;
         end

         unique case (state)
            IDLE: begin
               if (Write_Request) begin
                  addr <= {i_RCC_DMA_ADDR_HIGH,
                           i_RCC_DMA_ADDR_LOW[15:2], 2'b00};
                  len       <= i_RCC_BUFFER_LENGTH;
                  len_err   <= 1'b0;
                  byte_cnt  <= 6'd0;
                  pack_cnt  <= 2'd0;
                  pack_data <= 32'd0;
                  pack_strb <= 4'd0;
                  state <= (i_RCC_BUFFER_LENGTH == 6'd0) ? DONE : COLLECT;
               end
            end
            COLLECT: begin
               if (accept) begin
                  byte_cnt <= cnt_nxt[5:0];
                  pack_cnt <= pack_cnt + 2'd1;
                  pack_data <= push ? 32'd0 : word_data;
                  pack_strb <= push ? 4'd0 : word_strb;
               end
               // A clean end needs the last flag exactly on the length byte.
               if (term) begin
                  len_err <= (i_byte_last != at_len);
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               if (q_empty || ((q_cnt == Q_ONE) && pop)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dma_pattern_writer.sv
// Self-checking bench for dma_pattern_writer: vector table, corner
// sequences and randomized transfers against a byte-level model.
module tb_dma_pattern_writer;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] hi, lo;
   logic [5:0]  blen;
   logic        Write_Request;
   logic [7:0]  i_byte;
   logic        i_byte_valid, i_byte_last;
   logic        o_byte_ready;
   logic        DMA_WRITE;
   logic [31:0] DMA_WRITE_addr, DMA_WRITE_data;
   logic [3:0]  DMA_WRITE_strb;
   logic        rdy;
   logic        o_busy, o_done, o_len_error;

   always #5 CLK = ~CLK;

   dma_pattern_writer #(.WORD_Q_DEPTH(DEPTH)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .i_RCC_DMA_ADDR_HIGH(hi),
      .i_RCC_DMA_ADDR_LOW(lo),
      .i_RCC_BUFFER_LENGTH(blen),
      .Write_Request(Write_Request),
      .i_byte(i_byte),
      .i_byte_valid(i_byte_valid),
      .i_byte_last(i_byte_last),
      .o_byte_ready(o_byte_ready),
      .DMA_WRITE(DMA_WRITE),
      .DMA_WRITE_addr(DMA_WRITE_addr),
      .DMA_WRITE_data(DMA_WRITE_data),
      .DMA_WRITE_strb(DMA_WRITE_strb),
      .i_DMA_WRITE_ready(rdy),
      .o_busy(o_busy),
      .o_done(o_done),
      .o_len_error(o_len_error)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
   logic [3:0]  got_s[$], exp_s[$];
   logic [7:0]  bts [80];
   int done_n, done_cyc, last_pop_cyc, req_cyc, acc;
   int eacc;
   logic eerr;
   int rmode = 0;
   int hold = 0;

   typedef struct {
      logic [31:0] base;
      int len;
      int nb;
      int last;
      logic [7:0] b0;
      int mode;
      int nw;
      logic [31:0] ld;
      logic [3:0] ls;
      logic err;
   } vec_t;
   vec_t tv [7];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, got, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Write monitor with hold-stability check while stalled.
   initial begin
      logic stall;
      logic [31:0] st_a, st_d;
      logic [3:0] st_s;
      stall = 1'b0;
      st_a = '0;
      st_d = '0;
      st_s = '0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("hold_vld", 32'(DMA_WRITE), 32'd1);
               chk("hold_addr", DMA_WRITE_addr, st_a);
               chk("hold_data", DMA_WRITE_data, st_d);
               chk("hold_strb", 32'(DMA_WRITE_strb), 32'(st_s));
            end
            if (DMA_WRITE && rdy) begin
               got_a.push_back(DMA_WRITE_addr);
               got_d.push_back(DMA_WRITE_data);
               got_s.push_back(DMA_WRITE_strb);
               last_pop_cyc = cyc;
            end
            if (o_done) begin
               done_n++;
               done_cyc = cyc;
            end
            stall = DMA_WRITE && !rdy;
            st_a = DMA_WRITE_addr;
            st_d = DMA_WRITE_data;
            st_s = DMA_WRITE_strb;
         end
      end
   end

   // Ready source: 0 always, 1 random, 2 low for hold cycles, 3 never.
   initial begin
      rdy = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         case (rmode)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom_range(0, 1));
            2: begin
               if (hold > 0) begin
                  rdy = 1'b0;
                  hold--;
                  if (hold == 0) begin
                     @(negedge CLK);
                     chk("bp_bytes", 32'(acc), 32'(4 * DEPTH));
                     chk("bp_rdy", 32'(o_byte_ready), 32'd0);
                     chk("bp_nwr", 32'(got_a.size()), 32'd0);
                  end
               end else begin
                  rdy = 1'b1;
               end
            end
            default: rdy = 1'b0;
         endcase
      end
   end

   task automatic model(input logic [31:0] base, input int len,
                        input int last);
      exp_a.delete();
      exp_d.delete();
      exp_s.delete();
      if (len == 0) begin
         eacc = 0;
         eerr = 1'b0;
      end else begin
         int t;
         t = (last >= 0 && last < len) ? last : len - 1;
         eacc = t + 1;
         eerr = (last != len - 1);
         for (int k = 0; 4 * k < eacc; k++) begin
            logic [31:0] d;
            logic [3:0] s;
            d = '0;
            s = '0;
            for (int j = 0; j < 4; j++) begin
               if (4 * k + j < eacc) begin
                  d[8*j +: 8] = bts[4*k + j];
                  s[j] = 1'b1;
               end
            end
            exp_a.push_back((base & ~32'h3) + 32'(4 * k));
            exp_d.push_back(d);
            exp_s.push_back(s);
         end
      end
   endtask

   task automatic start(input logic [31:0] base, input int len);
      got_a.delete();
      got_d.delete();
      got_s.delete();
      done_n = 0;
      acc = 0;
      @(posedge CLK);
      #1;
      hi = base[31:16];
      lo = base[15:0];
      blen = 6'(len);
      Write_Request = 1'b1;
      req_cyc = cyc;
      @(posedge CLK);
      #1;
      Write_Request = 1'b0;
   endtask

   task automatic drive_bytes(input int nb, input int last, input bit poke);
      logic [15:0] sh, sl;
      logic [5:0] sn;
      sh = hi;
      sl = lo;
      sn = blen;
      for (int i = 0; i < nb; i++) begin
         bit ok;
         ok = 1'b0;
         i_byte = bts[i];
         i_byte_valid = 1'b1;
         i_byte_last = (i == last);
         if (poke && i == 2) begin
            Write_Request = 1'b1;
            hi = 16'hDEAD;
            lo = 16'hBEE0;
            blen = 6'd3;
         end
         for (int w = 0; w < 100; w++) begin
            @(negedge CLK);
            if (o_byte_ready) begin
               ok = 1'b1;
               break;
            end
            if (!o_busy) break;
         end
         if (ok) begin
            @(posedge CLK);
            #1;
            acc++;
         end
         Write_Request = 1'b0;
         hi = sh;
         lo = sl;
         blen = sn;
         if (!ok) break;
      end
      i_byte_valid = 1'b0;
      i_byte_last = 1'b0;
   endtask

   task automatic finish_chk(input int len);
      bit idle;
      int n;
      idle = 1'b0;
      for (int w = 0; w < 400; w++) begin
         @(negedge CLK);
         if (!o_busy) begin
            idle = 1'b1;
            break;
         end
      end
      chk("idle_timeout", 32'(idle), 32'd1);
      chk("n_writes", 32'(got_a.size()), 32'(exp_a.size()));
      n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
      for (int k = 0; k < n; k++) begin
         chk($sformatf("addr[%0d]", k), got_a[k], exp_a[k]);
         chk($sformatf("data[%0d]", k), got_d[k], exp_d[k]);
         chk($sformatf("strb[%0d]", k), 32'(got_s[k]), 32'(exp_s[k]));
      end
      chk("len_error", 32'(o_len_error), 32'(eerr));
      chk("bytes_acc", 32'(acc), 32'(eacc));
      chk("done_count", 32'(done_n), 32'd1);
      if (len == 0) chk("done_time", 32'(done_cyc), 32'(req_cyc + 1));
      else chk("done_time", 32'(done_cyc), 32'(last_pop_cyc + 1));
      chk("dma_quiet", 32'(DMA_WRITE), 32'd0);
   endtask

   task automatic run_xfer(input logic [31:0] base, input int len,
                           input int nb, input int last, input int mode,
                           input bit poke);
      rmode = mode;
      model(base, len, last);
      start(base, len);
      drive_bytes(nb, last, poke);
      finish_chk(len);
   endtask

   task automatic run_vec(input int i);
      for (int j = 0; j < 80; j++) bts[j] = tv[i].b0 + 8'(j);
      run_xfer(tv[i].base, tv[i].len, tv[i].nb, tv[i].last,
               tv[i].mode, 1'b0);
      chk($sformatf("tv%0d_nw", i), 32'(got_a.size()), 32'(tv[i].nw));
      chk($sformatf("tv%0d_err", i), 32'(o_len_error), 32'(tv[i].err));
      if (tv[i].nw > 0 && got_a.size() > 0) begin
         chk($sformatf("tv%0d_ldata", i), got_d[$], tv[i].ld);
         chk($sformatf("tv%0d_lstrb", i), 32'(got_s[$]), 32'(tv[i].ls));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{32'h2000_0010, 8, 8, 7, 8'h01, 0, 2,
                32'h0807_0605, 4'hF, 1'b0};
      tv[1] = '{32'h1000_0003, 6, 6, 5, 8'hA0, 0, 2,
                32'h0000_A5A4, 4'h3, 1'b0};
      tv[2] = '{32'h3000_0000, 8, 8, 4, 8'h10, 0, 2,
                32'h0000_0014, 4'h1, 1'b1};
      tv[3] = '{32'h3000_0100, 4, 5, -1, 8'h20, 0, 1,
                32'h2322_2120, 4'hF, 1'b1};
      tv[4] = '{32'h0000_0040, 0, 0, -1, 8'h00, 0, 0,
                32'h0, 4'h0, 1'b0};
      tv[5] = '{32'hFFFF_FFF0, 63, 63, 62, 8'h00, 1, 16,
                32'h003E_3D3C, 4'h7, 1'b0};
      tv[6] = '{32'h0800_0000, 5, 7, 6, 8'h40, 0, 2,
                32'h0000_0044, 4'h1, 1'b1};

      RESET = 1'b1;
      hi = '0;
      lo = '0;
      blen = '0;
      Write_Request = 1'b0;
      i_byte = '0;
      i_byte_valid = 1'b0;
      i_byte_last = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_dma", 32'(DMA_WRITE), 32'd0);
      chk("rst_addr", DMA_WRITE_addr, 32'd0);
      chk("rst_data", DMA_WRITE_data, 32'd0);
      chk("rst_strb", 32'(DMA_WRITE_strb), 32'd0);
      chk("rst_brdy", 32'(o_byte_ready), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_err", 32'(o_len_error), 32'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i);

      // Backpressure: queue fills, then drains in order.
      for (int j = 0; j < 80; j++) bts[j] = 8'($urandom);
      hold = 25;
      run_xfer(32'h6000_0000, 32, 32, 31, 2, 1'b0);

      // Request mid-COLLECT must not disturb the running transfer.
      for (int j = 0; j < 80; j++) bts[j] = 8'($urandom);
      run_xfer(32'h5000_0100, 12, 12, 11, 0, 1'b1);

      // Reset while draining two stalled words.
      for (int j = 0; j < 80; j++) bts[j] = 8'($urandom);
      rmode = 3;
      start(32'h4000_0000, 8);
      drive_bytes(8, 7, 1'b0);
      @(negedge CLK);
      chk("rst_pre_vld", 32'(DMA_WRITE), 32'd1);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_mid_dma", 32'(DMA_WRITE), 32'd0);
      chk("rst_mid_busy", 32'(o_busy), 32'd0);
      rmode = 0;
      repeat (6) @(negedge CLK);
      chk("rst_mid_nwr", 32'(got_a.size()), 32'd0);
      chk("rst_mid_done", 32'(done_n), 32'd0);
      run_vec(0);

      for (int r = 0; r < 25; r++) begin
         int len, last, sel;
         len = $urandom_range(0, 63);
         sel = $urandom_range(0, 2);
         if (sel == 0) last = -1;
         else if (sel == 1) last = len - 1;
         else last = (len > 0) ? $urandom_range(0, len - 1) : -1;
         for (int j = 0; j < 80; j++) bts[j] = 8'($urandom);
         run_xfer($urandom, len, len + 2, last, $urandom_range(0, 1), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end
endmodule
